// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, xtime, key-size modes, round counts, FSM states.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } aes_mode_e;

    localparam logic [3:0] NR_AES128 = 4'd10;
    localparam logic [3:0] NR_AES192 = 4'd12;
    localparam logic [3:0] NR_AES256 = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUND = 2'b01,
        DONE  = 2'b10
    } fsm_state_e;

    // Forward S-box; entry 0 sits in the most significant byte.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[x];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Reserved encoding 11 falls into the AES-256 round count.
    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (aes_mode_e'(m))
            AES128:  return NR_AES128;
            AES192:  return NR_AES192;
            default: return NR_AES256;
        endcase
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped on the last round), AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] next_state
);

    // Byte 0 is bits [127:120]; byte index = 4*column + row.
    logic [0:15][7:0] in_b;
    logic [0:15][7:0] sub_b;
    logic [0:15][7:0] shf_b;
    logic [0:15][7:0] mix_b;

    assign in_b = state;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sub_b[i] = sbox(in_b[i]);
    end

    // Row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_shf_col
        for (genvar r = 0; r < 4; r++) begin : g_shf_row
            assign shf_b[4*c+r] = sub_b[4*((c+r)%4)+r];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mix_b[4*c+0] = xtime(shf_b[4*c+0]) ^ xtime(shf_b[4*c+1]) ^ shf_b[4*c+1]
                            ^ shf_b[4*c+2] ^ shf_b[4*c+3];
        assign mix_b[4*c+1] = shf_b[4*c+0] ^ xtime(shf_b[4*c+1]) ^ xtime(shf_b[4*c+2])
                            ^ shf_b[4*c+2] ^ shf_b[4*c+3];
        assign mix_b[4*c+2] = shf_b[4*c+0] ^ shf_b[4*c+1] ^ xtime(shf_b[4*c+2])
                            ^ xtime(shf_b[4*c+3]) ^ shf_b[4*c+3];
        assign mix_b[4*c+3] = xtime(shf_b[4*c+0]) ^ shf_b[4*c+0] ^ shf_b[4*c+1]
                            ^ shf_b[4*c+2] ^ xtime(shf_b[4*c+3]);
    end

    assign next_state = (last_round ? shf_b : mix_b) ^ round_key;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption core, one round per clock.
// Optional macro AES_MODE_ERR_EN: adds mode_err and rejects mode 11 at accept;
// without it mode 11 runs as AES-256.
module aes_cipher_iter
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [14:0][127:0]    round_key,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          plaintext,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ciphertext,
`ifdef AES_MODE_ERR_EN
    output logic                  mode_err,
`endif
    output logic                  busy
);

    fsm_state_e   fsm;
    logic [127:0] state;
    logic [127:0] round_out;
    logic [3:0]   rnd;
    logic [3:0]   nr;
    logic         accept_en;
    logic         last_round;

    // Gated with reset so the port reads 0 during reset and 1 right after it.
    assign in_ready   = accept_en & ~reset;
    assign last_round = (rnd == nr);
    assign ciphertext = state;

    // Round keys are consumed live from the generator, never latched here.
    aes_round u_round (
        .state      (state),
        .round_key  (round_key[rnd]),
        .last_round (last_round),
        .next_state (round_out)
    );

    // Control FSM and data state register; all status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            state     <= '0;
            rnd       <= '0;
            nr        <= '0;
            accept_en <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_MODE_ERR_EN
            mode_err  <= 1'b0;
`endif
        end else begin
`ifdef AES_MODE_ERR_EN
            mode_err <= 1'b0;
`endif
            case (fsm)
                IDLE: begin
                    if (in_valid && accept_en) begin
`ifdef AES_MODE_ERR_EN
                        if (mode == 2'b11) begin
                            mode_err <= 1'b1;
                        end else begin
`endif
                            // Only the round count is taken from mode.
                            state     <= plaintext ^ round_key[0];
                            nr        <= nr_of(mode);
                            rnd       <= 4'd1;
                            fsm       <= ROUND;
                            busy      <= 1'b1;
                            accept_en <= 1'b0;
`ifdef AES_MODE_ERR_EN
                        end
`endif
                    end
                end
                ROUND: begin
                    state <= round_out;
                    if (last_round) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        accept_en <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    accept_en <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter using FIPS-197 appendix C vectors.
module tb_aes_cipher_iter;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           mode;
    logic [14:0][127:0]   round_key;
    logic                 in_valid;
    logic                 in_ready;
    logic [127:0]         plaintext;
    logic                 out_valid;
    logic                 out_ready;
    logic [127:0]         ciphertext;
    logic                 busy;
`ifdef AES_MODE_ERR_EN
    logic                 mode_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic [127:0] sb_q[$];

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_cipher_iter dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .round_key  (round_key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
`ifdef AES_MODE_ERR_EN
        .mode_err   (mode_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference key schedule built from first principles (field inverse + affine).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic logic [14:0][127:0] key_sched(input logic [255:0] key, input logic [1:0] m);
        logic [31:0]        w[60];
        logic [31:0]        t;
        logic [7:0]         rc = 8'h01;
        logic [14:0][127:0] rk = '0;
        int nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        int nrr = nk + 6;
        for (int i = 0; i < 4 * (nrr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nrr; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    // Offer one block to an idle DUT and record its expected result.
    task automatic send_block(input logic [255:0] key, input logic [1:0] m, input logic [127:0] exp_ct);
        round_key = key_sched(key, m);
        mode      = m;
        plaintext = PT;
        in_valid  = 1'b1;
        sb_q.push_back(exp_ct);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output bit timeout);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        timeout = !out_valid;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00;
        round_key = '0; plaintext = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || ciphertext !== 128'h0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b ct=%h, want 0/0/0/0",
                     in_ready, out_valid, busy, ciphertext);
        end
`ifdef AES_MODE_ERR_EN
        checks++;
        if (mode_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mode_err: got %b want 0", mode_err);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_ready: in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_fips(input string name, input logic [255:0] key, input logic [1:0] m,
                             input logic [127:0] exp_ct, input int nr);
        int cyc;
        bit timeout;
        logic [127:0] want;
        send_block(key, m, exp_ct);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_accept: busy=%b want 1", name, busy);
        end
        wait_out(cyc, timeout);
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL %s_timeout: out_valid never rose", name);
            void'(sb_q.pop_front());
        end else begin
            if (cyc !== nr) begin
                failures++;
                $display("FAIL %s_latency: got %0d cycles want %0d", name, cyc, nr);
            end
            want = sb_q.pop_front();
            checks++;
            if (ciphertext !== want) begin
                failures++;
                $display("FAIL %s_ct: got %h want %h", name, ciphertext, want);
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_return_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        bit timeout;
        logic [127:0] want;
        out_ready = 1'b0;
        send_block(K128, 2'b00, CT128);
        wait_out(cyc, timeout);
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL bp_timeout: out_valid never rose");
        end
        want = sb_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            plaintext = ~PT;
            checks++;
            if (ciphertext !== want || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: ct=%h ov=%b ir=%b busy=%b want %h/1/0/1",
                         i, ciphertext, out_valid, in_ready, busy, want);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        plaintext = PT;
        checks++;
        if (ciphertext !== want || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_final_hold: ct=%h ov=%b want %h/1", ciphertext, out_valid, want);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_round;
        send_block(K128, 2'b00, CT128);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy: busy=%b ov=%b want 1/0", busy, out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b ov=%b ir=%b want 0/0/0", busy, out_valid, in_ready);
        end
        sb_q.delete();
        reset = 1'b0;
        test_fips("after_reset", K128, 2'b00, CT128, 10);
    endtask

    task automatic test_reserved_mode;
`ifdef AES_MODE_ERR_EN
        round_key = key_sched(K256, 2'b10);
        mode      = 2'b11;
        plaintext = PT;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsv_ready_before: got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mode_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsv_reject: mode_err=%b busy=%b ir=%b want 1/0/1", mode_err, busy, in_ready);
        end
        @(negedge clk);
        checks++;
        if (mode_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rsv_pulse_end: mode_err=%b busy=%b want 0/0", mode_err, busy);
        end
        mode = 2'b00;
`else
        test_fips("reserved_as_256", K256, 2'b11, CT256, 14);
`endif
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int acc[2];
        logic [127:0] want;
        round_key = key_sched(K256, 2'b10);
        mode      = 2'b10;
        plaintext = PT;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (got < 2 && cyc < 80) begin
            if (sent == 2) in_valid = 1'b0;
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_out: ct=%h with empty scoreboard", ciphertext);
                end else begin
                    want = sb_q.pop_front();
                    if (ciphertext !== want) begin
                        failures++;
                        $display("FAIL b2b_ct[%0d]: got %h want %h", got, ciphertext, want);
                    end
                end
                got++;
            end
            if (in_valid && in_ready && sent < 2) begin
                acc[sent] = cyc;
                sent++;
                sb_q.push_back(CT256);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 2 || sent != 2) begin
            failures++;
            $display("FAIL b2b_count: sent=%0d got=%0d want 2/2", sent, got);
        end else begin
            checks++;
            if (acc[1] - acc[0] != 16) begin
                failures++;
                $display("FAIL b2b_throughput: accept spacing %0d want 16", acc[1] - acc[0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_fips("aes128", K128, 2'b00, CT128, 10);
        test_fips("aes192", K192, 2'b01, CT192, 12);
        test_fips("aes256", K256, 2'b10, CT256, 14);
        test_backpressure;
        test_reset_mid_round;
        test_reserved_mode;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
